imem_sync_loader: RTL and testbench
===================================

Name: imem_sync_loader

Overview:
- Parametrised, synchronous-read instruction memory for the 37-bit ISA core; successor to the combinational 1024x37 array.
- Adds a hardware boot-clear sequencer in place of the simulation-only initial loop.
- Adds a handshaked program-load write port, so programs load through RTL rather than testbench backdoor.
- Fetch read path is registered with a valid flag.
- Sits between the fetch stage (read side) and the program loader / debug host (write side).

Parameters:
- DATA_W, 37, instruction width in bits.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of implemented words; must be <= 2**ADDR_W.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- init_done  output  1  high once boot-clear has completed.
- ld_valid  input  1  load beat request.
- ld_ready  output  1  load port can accept a beat.
- ld_addr  input  ADDR_W  load word address.
- ld_data  input  DATA_W  load word data.
- fetch_req  input  1  fetch request.
- fetch_ready  output  1  fetch can be accepted this cycle.
- fetch_addr  input  ADDR_W  fetch word address.
- instr_valid  output  1  instruction holds a fresh fetch result this cycle.
- instruction  output  DATA_W  fetched word.
- fetch_oob  output  1  last accepted fetch address was >= DEPTH.
- parity_err  output  1  parity mismatch on last accepted fetch; tied 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, any time, including mid-clear or mid-load):
  - State goes to CLEAR and clr_cnt goes to 0.
  - init_done, ld_ready, fetch_ready, instr_valid, fetch_oob and parity_err go to 0; instruction goes to 0.
  - Any in-flight load or fetch is abandoned.
  - A full clear always re-runs after reset deasserts.
- CLEAR state:
  - Each cycle writes 0 (NOP) to mem[clr_cnt] and increments clr_cnt.
  - After writing word DEPTH-1, moves to READY on the next edge.
  - Clear takes exactly DEPTH cycles.
  - ld_ready and fetch_ready are held 0 throughout; ld_valid and fetch_req are ignored.
- READY state:
  - init_done=1 and ld_ready=1.
  - fetch_ready = init_done AND NOT ld_valid, so load has priority and the single port is never shared in one cycle.
  - The state is left only by reset.
- Load beat (ld_valid && ld_ready at a clock edge):
  - Writes ld_data to mem[ld_addr] when ld_addr < DEPTH.
  - When ld_addr >= DEPTH the beat is accepted and silently dropped; memory is unchanged.
- Fetch (fetch_req && fetch_ready at edge N):
  - At edge N+1: instr_valid=1, instruction=mem[fetch_addr], fetch_oob=0.
  - Fixed 1-cycle latency; back-to-back fetches give one result per cycle.
- Fetch with fetch_addr >= DEPTH:
  - instr_valid=1, instruction=0 (NOP), fetch_oob=1.
- No accepted fetch at edge N:
  - At edge N+1 instr_valid=0.
  - instruction, fetch_oob and parity_err hold their last values.
- Read-after-write: a fetch accepted the cycle after a load beat to the same address returns the newly written data.
- fetch_req asserted while fetch_ready=0 is not queued; the requester must hold or retry.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each stored word carries an extra even-parity bit, computed on load and set to 0 by clear (parity of the all-zero word).
  - On each accepted in-range fetch, parity is recomputed over the read data.
  - parity_err is registered alongside instruction: 1 when the stored and recomputed parity differ, else 0.
  - Out-of-range fetches give parity_err=0.
  - A debug-only input-free force is not provided; the bench injects errors by hierarchical bit flip of the stored parity bit.
- Not defined: no parity storage and parity_err is constant 0.

Test Plan:
- Boot clear: reset for 3 cycles, then release → init_done rises exactly DEPTH cycles later (1024 with defaults). A fetch from address 5 then returns 0 with instr_valid=1 one cycle after acceptance.
- Load/fetch: load 37'h1_2345_6789 to address 0x3FF, then fetch 0x3FF → instruction=37'h1_2345_6789 with instr_valid=1 the next cycle. Back-to-back fetches of 0x000 and 0x3FF give 0 then 37'h1_2345_6789 on consecutive cycles.
- Load priority: ld_valid=1 and fetch_req=1 in the same cycle → fetch_ready=0 and only the load completes. Fetch is accepted the following cycle and returns the new data.
- Out-of-range: with DEPTH=512, a load to address 600 leaves memory unchanged, and a fetch of 600 gives instruction=0 with fetch_oob=1. The next fetch of 10 gives fetch_oob=0.
- Reset mid-clear and mid-stream: assert reset at clear cycle 300 → init_done stays 0 until a full DEPTH-cycle clear completes. Asserting reset during back-to-back fetches drops instr_valid to 0 immediately without waiting for a clock, and previously loaded words read back as 0 after the re-clear.
- Parity (IMEM_PARITY_EN): load 37'h0_0000_0001 to address 7, flip its stored parity bit, then fetch 7 → parity_err=1. A fetch of untouched address 8 gives parity_err=0.

Source files
------------

// File: rtl/imem_sync_loader.sv
// Synchronous-read instruction memory with a boot-clear sequencer and a handshaked load port.
// Optional per-word even parity is compiled in with `define IMEM_PARITY_EN.
module imem_sync_loader #(
  parameter int DATA_W = 37,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              fetch_oob,
  output logic              parity_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_init_done;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_we;
  logic [IDX_W-1:0]    w_wa;
  logic [DATA_W-1:0]   w_wd;

  logic                w_ld_in;
  logic                w_fa_in;
  logic [IDX_W-1:0]    w_ld_idx;
  logic [IDX_W-1:0]    w_fa_idx;
  logic                w_fetch_acc;

  logic                r_instr_valid;
  logic [DATA_W-1:0]   r_instruction;
  logic                r_fetch_oob;

  assign w_ld_in  = ({1'b0, ld_addr} < DEPTH_L);
  assign w_fa_in  = ({1'b0, fetch_addr} < DEPTH_L);
  assign w_ld_idx = ld_addr[IDX_W-1:0];
  assign w_fa_idx = fetch_addr[IDX_W-1:0];

  // Load owns the single port whenever it is requested, so a fetch only goes when ld_valid is low.
  assign init_done   = r_init_done;
  assign ld_ready    = r_init_done;
  assign fetch_ready = r_init_done & ~ld_valid;
  assign w_fetch_acc = fetch_req & fetch_ready;

  assign instr_valid = r_instr_valid;
  assign instruction = r_instruction;
  assign fetch_oob   = r_fetch_oob;

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH];
  logic w_wpar;
  logic r_parity_err;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= {ADDR_W{1'b0}};
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_cnt_nxt;
      r_init_done <= (w_state_nxt == ST_READY);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clr_cnt;
    w_we        = 1'b0;
    w_wa        = {IDX_W{1'b0}};
    w_wd        = {DATA_W{1'b0}};
`ifdef IMEM_PARITY_EN
    w_wpar      = 1'b0;
`endif
    case (r_state)
      ST_CLEAR: begin
        w_we      = 1'b1;
        w_wa      = r_clr_cnt[IDX_W-1:0];
        w_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == LAST_CNT) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
        // Out-of-range beats are accepted but never reach the array.
        if (ld_valid) begin
          w_we = w_ld_in;
          w_wa = w_ld_idx;
          w_wd = ld_data;
`ifdef IMEM_PARITY_EN
          w_wpar = even_par(ld_data);
`endif
        end else begin
          w_we = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = {ADDR_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wa] <= w_wd;
    end
  end

`ifdef IMEM_PARITY_EN
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_par[w_wa] <= w_wpar;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else if (w_fetch_acc) begin
      if (w_fa_in) begin
        r_parity_err <= (even_par(r_mem[w_fa_idx]) != r_par[w_fa_idx]);
      end else begin
        r_parity_err <= 1'b0;
      end
    end
  end
`endif

  // Fetch result register: one-cycle latency, holds data and flags when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_valid <= 1'b0;
      r_instruction <= {DATA_W{1'b0}};
      r_fetch_oob   <= 1'b0;
    end else begin
      r_instr_valid <= w_fetch_acc;
      if (w_fetch_acc) begin
        if (w_fa_in) begin
          r_instruction <= r_mem[w_fa_idx];
          r_fetch_oob   <= 1'b0;
        end else begin
          r_instruction <= {DATA_W{1'b0}};
          r_fetch_oob   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_sync_loader.sv
// Bench for imem_sync_loader: two instances (DEPTH 1024 and 512) share one random stimulus stream
// and are compared every cycle against an array-based model; directed steps pin the model with literals.
module tb_imem_sync_loader;
  localparam int DW = 37;
  localparam int AW = 10;
  localparam int D0 = 1024;
  localparam int D1 = 512;
  localparam logic [DW-1:0] X_WORD = 37'h1_2345_6789;
  localparam logic [DW-1:0] Y_WORD = 37'h0_ABCD_0123;
  localparam logic [DW-1:0] Z_WORD = 37'h1_F00D_BEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;

  logic [1:0] init_done_v, ld_ready_v, fetch_ready_v, instr_valid_v, fetch_oob_v, parity_err_v;
  logic [1:0][DW-1:0] instr_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_sync_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D0)) dut0 (
    .clk(clk), .reset(reset), .init_done(init_done_v[0]),
    .ld_valid(ld_valid), .ld_ready(ld_ready_v[0]), .ld_addr(ld_addr), .ld_data(ld_data),
    .fetch_req(fetch_req), .fetch_ready(fetch_ready_v[0]), .fetch_addr(fetch_addr),
    .instr_valid(instr_valid_v[0]), .instruction(instr_v[0]),
    .fetch_oob(fetch_oob_v[0]), .parity_err(parity_err_v[0])
  );

  imem_sync_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D1)) dut1 (
    .clk(clk), .reset(reset), .init_done(init_done_v[1]),
    .ld_valid(ld_valid), .ld_ready(ld_ready_v[1]), .ld_addr(ld_addr), .ld_data(ld_data),
    .fetch_req(fetch_req), .fetch_ready(fetch_ready_v[1]), .fetch_addr(fetch_addr),
    .instr_valid(instr_valid_v[1]), .instruction(instr_v[1]),
    .fetch_oob(fetch_oob_v[1]), .parity_err(parity_err_v[1])
  );

  function automatic int depth_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Reference model: memory contents and expected outputs derived from the rules directly.
  logic [DW-1:0] m_mem [2][1024];
  bit            m_bad [2][1024];
  bit            m_ready [2];
  int            m_cnt [2];
  bit            e_valid [2];
  bit            e_oob [2];
  bit            e_perr [2];
  logic [DW-1:0] e_instr [2];
`ifdef IMEM_PARITY_EN
  logic          flip_par = 1'b0;
  logic [AW-1:0] flip_addr = '0;
`endif

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_ready[i] = 1'b0;
        m_cnt[i]   = 0;
        e_valid[i] = 1'b0;
        e_oob[i]   = 1'b0;
        e_perr[i]  = 1'b0;
        e_instr[i] = '0;
        for (int j = 0; j < 1024; j++) begin
          m_mem[i][j] = '0;
          m_bad[i][j] = 1'b0;
        end
      end else begin
`ifdef IMEM_PARITY_EN
        if (flip_par && int'(flip_addr) < depth_of(i)) m_bad[i][flip_addr] = ~m_bad[i][flip_addr];
`endif
        if (!m_ready[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == depth_of(i)) m_ready[i] = 1'b1;
          e_valid[i] = 1'b0;
        end else if (ld_valid) begin
          if (int'(ld_addr) < depth_of(i)) begin
            m_mem[i][ld_addr] = ld_data;
            m_bad[i][ld_addr] = 1'b0;
          end
          e_valid[i] = 1'b0;
        end else if (fetch_req) begin
          e_valid[i] = 1'b1;
          if (int'(fetch_addr) < depth_of(i)) begin
            e_instr[i] = m_mem[i][fetch_addr];
            e_oob[i]   = 1'b0;
            e_perr[i]  = m_bad[i][fetch_addr];
          end else begin
            e_instr[i] = '0;
            e_oob[i]   = 1'b1;
            e_perr[i]  = 1'b0;
          end
        end else begin
          e_valid[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("init_done",   i, 64'(init_done_v[i]),   64'(m_ready[i]));
      chk("ld_ready",    i, 64'(ld_ready_v[i]),    64'(m_ready[i]));
      chk("fetch_ready", i, 64'(fetch_ready_v[i]), 64'(m_ready[i] && !ld_valid));
      chk("instr_valid", i, 64'(instr_valid_v[i]), 64'(e_valid[i]));
      chk("instruction", i, 64'(instr_v[i]),       64'(e_instr[i]));
      chk("fetch_oob",   i, 64'(fetch_oob_v[i]),   64'(e_oob[i]));
      chk("parity_err",  i, 64'(parity_err_v[i]),  64'(e_perr[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic fr, input logic [AW-1:0] fa);
    ld_valid = lv; ld_addr = la; ld_data = ld; fetch_req = fr; fetch_addr = fa;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  // Counts edges from reset release until each instance raises init_done.
  task automatic boot_count();
    int k = 0;
    int f0 = -1;
    int f1 = -1;
    while ((f0 < 0 || f1 < 0) && k < 3000) begin
      tick();
      k++;
      if (f0 < 0 && init_done_v[0]) f0 = k;
      if (f1 < 0 && init_done_v[1]) f1 = k;
    end
    chk("boot_len", 0, 64'(f0), 64'(D0));
    chk("boot_len", 1, 64'(f1), 64'(D1));
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    boot_count();

    drive(1'b0, '0, '0, 1'b1, 10'd5);
    tick();
    chk("fetch5_valid", 0, 64'(instr_valid_v[0]), 64'd1);
    chk("fetch5_data",  0, 64'(instr_v[0]),       64'd0);

    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (300) tick();
    chk("midclear_done", 0, 64'(init_done_v[0]), 64'd0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    boot_count();

    drive(1'b1, 10'h3FF, X_WORD, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 10'h3FF);
    tick();
    chk("ld3ff_data",  0, 64'(instr_v[0]),       64'(X_WORD));
    chk("ld3ff_valid", 0, 64'(instr_valid_v[0]), 64'd1);
    chk("ld3ff_oob",   1, 64'(fetch_oob_v[1]),   64'd1);
    chk("ld3ff_data",  1, 64'(instr_v[1]),       64'd0);
    drive(1'b0, '0, '0, 1'b1, 10'h000);
    tick();
    chk("b2b_first", 0, 64'(instr_v[0]), 64'd0);
    drive(1'b0, '0, '0, 1'b1, 10'h3FF);
    tick();
    chk("b2b_second", 0, 64'(instr_v[0]), 64'(X_WORD));
    chk("b2b_valid",  0, 64'(instr_valid_v[0]), 64'd1);

    drive(1'b1, 10'd20, Y_WORD, 1'b1, 10'd20);
    #1;
    chk("prio_fready", 0, 64'(fetch_ready_v[0]), 64'd0);
    chk("prio_fready", 1, 64'(fetch_ready_v[1]), 64'd0);
    tick();
    chk("prio_novalid", 0, 64'(instr_valid_v[0]), 64'd0);
    drive(1'b0, '0, '0, 1'b1, 10'd20);
    tick();
    chk("prio_raw", 0, 64'(instr_v[0]), 64'(Y_WORD));
    chk("prio_raw", 1, 64'(instr_v[1]), 64'(Y_WORD));

    drive(1'b1, 10'd600, Z_WORD, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 10'd600);
    tick();
    chk("oob_data", 1, 64'(instr_v[1]),     64'd0);
    chk("oob_flag", 1, 64'(fetch_oob_v[1]), 64'd1);
    chk("inr_data", 0, 64'(instr_v[0]),     64'(Z_WORD));
    drive(1'b0, '0, '0, 1'b1, 10'd10);
    tick();
    chk("oob_clear", 1, 64'(fetch_oob_v[1]), 64'd0);
    idle();
    tick();
    chk("idle_hold", 1, 64'(instr_valid_v[1]), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      logic lv, fr;
      logic [AW-1:0] la, fa;
      lv = ($urandom_range(0, 99) < 25);
      fr = ($urandom_range(0, 99) < 65);
      la = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom);
      fa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom);
      drive(lv, la, {$urandom, $urandom}, fr, fa);
      tick();
    end

    drive(1'b1, 10'h3FF, X_WORD, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 10'h3FF);
    tick();
    drive(1'b0, '0, '0, 1'b1, 10'h000);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 0, 64'(instr_valid_v[0]), 64'd0);
    chk("rst_async_valid", 1, 64'(instr_valid_v[1]), 64'd0);
    chk("rst_async_done",  0, 64'(init_done_v[0]),   64'd0);
    idle();
    tick();
    reset = 1'b0;
    boot_count();
    drive(1'b0, '0, '0, 1'b1, 10'h3FF);
    tick();
    chk("reclear_data",  0, 64'(instr_v[0]),       64'd0);
    chk("reclear_valid", 0, 64'(instr_valid_v[0]), 64'd1);

`ifdef IMEM_PARITY_EN
    drive(1'b1, 10'd7, 37'h0_0000_0001, 1'b0, '0);
    tick();
    idle();
    flip_addr = 10'd7;
    flip_par = 1'b1;
    dut0.r_par[7] = ~dut0.r_par[7];
    dut1.r_par[7] = ~dut1.r_par[7];
    tick();
    flip_par = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 10'd7);
    tick();
    chk("par_err7", 0, 64'(parity_err_v[0]), 64'd1);
    chk("par_err7", 1, 64'(parity_err_v[1]), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 10'd8);
    tick();
    chk("par_ok8", 0, 64'(parity_err_v[0]), 64'd0);
`else
    drive(1'b0, '0, '0, 1'b1, 10'd7);
    tick();
    chk("par_tied0", 0, 64'(parity_err_v[0]), 64'd0);
`endif

    idle();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
